// File: rtl/sub_operand_stager.sv
// sub_operand_stager: front stage of the FP32 subtraction unit.
// Accepts an operand pair over a valid/ready handshake and classifies both
// operands. Special operand pairs are resolved here. Normal pairs are run on
// the downstream subtractor, with a timeout abort. The result is returned
// over a second valid/ready handshake.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready, in_a/in_b operand handshake (minuend, subtrahend)
//   sub_a/sub_b, flag_a/flag_b   latched operands and their class flags
//   available                    start/hold for the subtractor
//   sub_out/sub_done             subtractor result and its valid
//   res_valid/res_ready          result handshake
//   res_data/res_err             difference a-b, timeout abort flag
module sub_operand_stager #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] QNAN_CANON     = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  output logic [4:0]  flag_a,
  output logic [4:0]  flag_b,
  output logic        available,
  input  logic [31:0] sub_out,
  input  logic        sub_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SPECIAL,
    S_RUN,
    S_HOLD
  } state_e;

  // One-hot class: [0] zero [1] denormal [2] inf [3] qNaN [4] sNaN; 0 = normal
  function automatic logic [4:0] classify(input logic [31:0] x);
    logic exp_zero;
    logic exp_max;
    logic man_zero;
    exp_zero = (x[30:23] == 8'h00);
    exp_max  = (x[30:23] == 8'hFF);
    man_zero = (x[22:0] == 23'd0);
    classify = 5'b00000;
    if (exp_zero) begin
      classify = man_zero ? 5'b00001 : 5'b00010;
    end else if (exp_max) begin
      if (man_zero)   classify = 5'b00100;
      else if (x[22]) classify = 5'b01000;
      else            classify = 5'b10000;
    end
  endfunction

  // Result for pairs with at least one special operand; denormals act as signed zero
  function automatic logic [31:0] special_result(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [4:0]  fa,
                                                 input logic [4:0]  fb);
    logic [31:0] neg_b;
    neg_b = {~b[31], b[30:0]};
    if ((|fa[4:3]) || (|fb[4:3]))     special_result = QNAN_CANON;
    else if (fa[2] && fb[2])          special_result = (a[31] == b[31]) ? QNAN_CANON : a;
    else if (fa[2])                   special_result = a;
    else if (fb[2])                   special_result = neg_b;
    else if ((|fa[1:0]) && (|fb[1:0])) special_result = {a[31] & ~b[31], 31'd0};
    else if (|fb[1:0])                special_result = a;
    else                              special_result = neg_b;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic [4:0]        flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              res_valid_q, res_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              available_q, available_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    sub_a_d     = sub_a_q;
    sub_b_d     = sub_b_q;
    flag_a_d    = flag_a_q;
    flag_b_d    = flag_b_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    cnt_d       = cnt_q;
    available_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sub_a_d  = in_a;
          sub_b_d  = in_b;
          flag_a_d = classify(in_a);
          flag_b_d = classify(in_b);
          state_d  = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        state_d = ((|flag_a_q) || (|flag_b_q)) ? S_SPECIAL : S_RUN;
      end
      S_SPECIAL: begin
        res_data_d = special_result(sub_a_q, sub_b_q, flag_a_q, flag_b_q);
        res_err_d  = 1'b0;
        state_d    = S_HOLD;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // sub_done takes priority over a coincident timeout
        if (sub_done) begin
          res_data_d = sub_out;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d = QNAN_CANON;
          res_err_d  = 1'b1;
          state_d    = S_HOLD;
        end else begin
          available_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sub_a_q     <= '0;
      sub_b_q     <= '0;
      flag_a_q    <= '0;
      flag_b_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      available_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      flag_a_q    <= flag_a_d;
      flag_b_q    <= flag_b_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      available_q <= available_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sub_a     = sub_a_q;
  assign sub_b     = sub_b_q;
  assign flag_a    = flag_a_q;
  assign flag_b    = flag_b_q;
  assign available = available_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_sub_operand_stager.sv
// Testbench for sub_operand_stager: directed steps, expected results queued
// when a pair is driven and compared when the result handshake completes.
module tb_sub_operand_stager;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic [4:0]  flag_a;
  logic [4:0]  flag_b;
  logic        available;
  logic [31:0] sub_out;
  logic        sub_done;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  logic avail_seen;

  sub_operand_stager dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .flag_a   (flag_a),
    .flag_b   (flag_b),
    .available(available),
    .sub_out  (sub_out),
    .sub_done (sub_done),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_err  (res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one pair; returns at the falling edge just after the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    avail_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait for res_valid; cyc counts clock edges after the accept edge
  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (available) avail_seen = 1'b1;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  // Compare against the scoreboard head, then complete the handshake
  task automatic pop_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, res_data, e.data);
      chk({tag, "_err"}, 32'(res_err), 32'(e.err));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_rv_clr"}, 32'(res_valid), 32'd0);
  endtask

  task automatic special(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic [4:0] fa, input logic [4:0] fb);
    int cyc;
    sb.push_back('{data: exp_d, err: 1'b0});
    send(a, b);
    chk({tag, "_flag_a"}, 32'(flag_a), 32'(fa));
    chk({tag, "_flag_b"}, 32'(flag_b), 32'(fb));
    wait_res(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd2);
    chk({tag, "_avail"}, 32'(avail_seen), 32'd0);
    pop_result(tag);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    sub_out   = '0;
    sub_done  = 1'b0;
    res_ready = 1'b0;
    avail_seen = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_available", 32'(available), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_sub_a", sub_a, 32'd0);
    chk("rst_flag_a", 32'(flag_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sub_done while idle is ignored
    @(negedge clk);
    sub_done = 1'b1;
    sub_out  = 32'hDEADBEEF;
    @(negedge clk);
    sub_done = 1'b0;
    chk("idle_done_rv", 32'(res_valid), 32'd0);
    chk("idle_done_rdy", 32'(in_ready), 32'd1);

    // Normal pair 3.0 - 1.0 through the subtractor
    sb.push_back('{data: 32'h40000000, err: 1'b0});
    send(32'h40400000, 32'h3F800000);
    chk("norm_sub_a", sub_a, 32'h40400000);
    chk("norm_sub_b", sub_b, 32'h3F800000);
    chk("norm_flags", 32'({flag_a, flag_b}), 32'd0);
    chk("norm_avail_t0", 32'(available), 32'd0);
    @(negedge clk);
    chk("norm_avail_t1", 32'(available), 32'd0);
    @(negedge clk);
    chk("norm_avail_t2", 32'(available), 32'd1);
    repeat (3) @(negedge clk);
    sub_done = 1'b1;
    sub_out  = 32'h40000000;
    @(negedge clk);
    sub_done = 1'b0;
    sub_out  = 32'h0;
    chk("norm_rv", 32'(res_valid), 32'd1);
    chk("norm_avail_drop", 32'(available), 32'd0);
    pop_result("norm");

    // Special operand pairs
    special("qnan_a",   32'h7FC00001, 32'h3F800000, QNAN,         5'b01000, 5'b00000);
    special("snan_b",   32'h3F800000, 32'h7F800001, QNAN,         5'b00000, 5'b10000);
    special("inf_same", 32'h7F800000, 32'h7F800000, QNAN,         5'b00100, 5'b00100);
    special("inf_opp",  32'h7F800000, 32'hFF800000, 32'h7F800000, 5'b00100, 5'b00100);
    special("fin_minf", 32'h3F800000, 32'hFF800000, 32'h7F800000, 5'b00000, 5'b00100);
    special("inf_fin",  32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00100, 5'b00000);
    special("nz_mz",    32'h80000000, 32'h00000000, 32'h80000000, 5'b00001, 5'b00001);
    special("pz_pz",    32'h00000000, 32'h00000000, 32'h00000000, 5'b00001, 5'b00001);
    special("a_bzero",  32'h40400000, 32'h80000000, 32'h40400000, 5'b00000, 5'b00001);
    special("den_one",  32'h00000001, 32'h3F800000, 32'hBF800000, 5'b00010, 5'b00000);

    // Timeout: subtractor never answers
    sb.push_back('{data: QNAN, err: 1'b1});
    send(32'h40400000, 32'h3F800000);
    repeat (10) @(negedge clk);
    chk("to_avail_mid", 32'(available), 32'd1);
    cyc = 10;
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_lat", 32'(cyc), 32'd65);
    chk("to_avail", 32'(available), 32'd0);
    pop_result("timeout");

    // sub_done coincident with the timeout cycle wins
    sb.push_back('{data: 32'h12345678, err: 1'b0});
    send(32'h40400000, 32'h3F800000);
    repeat (64) @(negedge clk);
    chk("tie_rv_pre", 32'(res_valid), 32'd0);
    sub_done = 1'b1;
    sub_out  = 32'h12345678;
    @(negedge clk);
    sub_done = 1'b0;
    chk("tie_rv", 32'(res_valid), 32'd1);
    pop_result("tie");

    // Backpressure: result stays put, new pairs and sub_done are ignored
    sb.push_back('{data: 32'h40400000, err: 1'b0});
    send(32'h40400000, 32'h00000000);
    wait_res(cyc);
    in_valid = 1'b1;
    in_a     = 32'h11111111;
    in_b     = 32'h22222222;
    sub_done = 1'b1;
    sub_out  = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", res_data, 32'h40400000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_rv", 32'(res_valid), 32'd1);
    end
    in_valid = 1'b0;
    sub_done = 1'b0;
    chk("bp_sub_a", sub_a, 32'h40400000);
    pop_result("bp");

    // Reset during RUN drops available at once
    send(32'h40400000, 32'h3F800000);
    repeat (3) @(negedge clk);
    chk("rr_avail_pre", 32'(available), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_avail", 32'(available), 32'd0);
    chk("rr_in_ready", 32'(in_ready), 32'd1);
    chk("rr_sub_a", sub_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_idle_rv", 32'(res_valid), 32'd0);
    chk("rr_idle_avail", 32'(available), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
